// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states, ALU ops
// and the per-state control word decoded by the FSM.
package mc_ctrl_pkg;

  localparam int unsigned OP_RTYPE = 0;
  localparam int unsigned OP_LW    = 1;
  localparam int unsigned OP_SW    = 2;
  localparam int unsigned OP_BEQ   = 3;
  localparam int unsigned OP_ADDI  = 4;
  localparam int unsigned OP_J     = 5;
  localparam int unsigned OP_BNE   = 6;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_BNE    = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_FUNCT
  } aluop_t;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [2:0] ALUCTL_AND = 3'b000;
  localparam logic [2:0] ALUCTL_OR  = 3'b001;
  localparam logic [2:0] ALUCTL_ADD = 3'b010;
  localparam logic [2:0] ALUCTL_SUB = 3'b110;
  localparam logic [2:0] ALUCTL_SLT = 3'b111;

  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       branchne;
    aluop_t     aluop;
  } ctrl_t;

  // Moore control word per state; irwrite/pcwrite in FETCH are later gated by mem_ready.
  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c       = '0;
    c.aluop = ALU_ADD;
    case (s)
      S_FETCH: begin
        c.memread = 1'b1;
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
        c.alusrcb = 2'b01;
      end
      S_DECODE: c.alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD: begin
        c.iord    = 1'b1;
        c.memread = 1'b1;
      end
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_EXEC: begin
        c.alusrca = 1'b1;
        c.aluop   = ALU_FUNCT;
      end
      S_ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BEQ, S_BNE: begin
        c.alusrca  = 1'b1;
        c.aluop    = ALU_SUB;
        c.pcsrc    = 2'b01;
        c.branch   = (s == S_BEQ);
        c.branchne = (s == S_BNE);
      end
      S_ADDIWB: c.regwrite = 1'b1;
      S_JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c = c;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the instruction register/datapath and the multicycle controller.
interface multicycle_controller_if #(
  parameter int unsigned OP_W      = 5,
  parameter int unsigned FUNCT_W   = 6,
  parameter int unsigned ALUCTRL_W = 3
);
  logic [OP_W-1:0]      op;
  logic [FUNCT_W-1:0]   funct;
  logic                 zero;
  logic                 mem_ready;
  logic                 iord;
  logic                 irwrite;
  logic                 memread;
  logic                 memwrite;
  logic                 memtoreg;
  logic                 regdst;
  logic                 regwrite;
  logic                 alusrca;
  logic [1:0]           alusrcb;
  logic [1:0]           pcsrc;
  logic                 pcen;
  logic [ALUCTRL_W-1:0] alucontrol;
  logic                 illegal_op;
  logic [3:0]           state_o;

  modport master (
    input  op, funct, zero, mem_ready,
    output iord, irwrite, memread, memwrite, memtoreg, regdst, regwrite, alusrca,
           alusrcb, pcsrc, pcen, alucontrol, illegal_op, state_o
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  iord, irwrite, memread, memwrite, memtoreg, regdst, regwrite, alusrca,
           alusrcb, pcsrc, pcen, alucontrol, illegal_op, state_o
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: FSM ALU op plus R-type funct to alucontrol.
module alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned FUNCT_W   = 6,
  parameter int unsigned ALUCTRL_W = 3
) (
  input  aluop_t               aluop,
  input  logic [FUNCT_W-1:0]   funct,
  output logic [ALUCTRL_W-1:0] alucontrol
);

  always_comb begin
    alucontrol = ALUCTRL_W'(ALUCTL_ADD);
    case (aluop)
      ALU_SUB: alucontrol = ALUCTRL_W'(ALUCTL_SUB);
      ALU_FUNCT: begin
        case (funct)
          FUNCT_W'(FUNCT_ADD): alucontrol = ALUCTRL_W'(ALUCTL_ADD);
          FUNCT_W'(FUNCT_SUB): alucontrol = ALUCTRL_W'(ALUCTL_SUB);
          FUNCT_W'(FUNCT_AND): alucontrol = ALUCTRL_W'(ALUCTL_AND);
          FUNCT_W'(FUNCT_OR):  alucontrol = ALUCTRL_W'(ALUCTL_OR);
          FUNCT_W'(FUNCT_SLT): alucontrol = ALUCTRL_W'(ALUCTL_SLT);
          default:             alucontrol = ALUCTRL_W'(ALUCTL_ADD);
        endcase
      end
      default: alucontrol = ALUCTRL_W'(ALUCTL_ADD);
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle Moore control FSM with memory wait states, BEQ/BNE and a sticky illegal-opcode flag.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OP_W      = 5,
  parameter int unsigned FUNCT_W   = 6,
  parameter int unsigned ALUCTRL_W = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   illegal_q, illegal_d;
  logic [ALUCTRL_W-1:0] alucontrol;

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_W'(OP_LW), OP_W'(OP_SW): state_d = S_MEMADR;
          OP_W'(OP_RTYPE):            state_d = S_EXEC;
          OP_W'(OP_BEQ):              state_d = S_BEQ;
          OP_W'(OP_BNE):              state_d = S_BNE;
          OP_W'(OP_ADDI):             state_d = S_ADDIEX;
          OP_W'(OP_J):                state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (bus.op == OP_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
    ctrl_d = ctrl_for(state_d);
  end

  // Control word is registered from the next state so outputs are flops yet track state_q exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ctrl_q    <= ctrl_for(S_FETCH);
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  alu_decoder #(
    .FUNCT_W   (FUNCT_W),
    .ALUCTRL_W (ALUCTRL_W)
  ) u_alu_decoder (
    .aluop      (ctrl_q.aluop),
    .funct      (bus.funct),
    .alucontrol (alucontrol)
  );

  // irwrite marks FETCH: there the PC update waits for the memory, elsewhere pcwrite is unconditional.
  assign bus.pcen = (ctrl_q.pcwrite & (~ctrl_q.irwrite | bus.mem_ready))
                  | (ctrl_q.branch & bus.zero)
                  | (ctrl_q.branchne & ~bus.zero);

  assign bus.irwrite    = ctrl_q.irwrite & bus.mem_ready;
  assign bus.iord       = ctrl_q.iord;
  assign bus.memread    = ctrl_q.memread;
  assign bus.memwrite   = ctrl_q.memwrite;
  assign bus.memtoreg   = ctrl_q.memtoreg;
  assign bus.regdst     = ctrl_q.regdst;
  assign bus.regwrite   = ctrl_q.regwrite;
  assign bus.alusrca    = ctrl_q.alusrca;
  assign bus.alusrcb    = ctrl_q.alusrcb;
  assign bus.pcsrc      = ctrl_q.pcsrc;
  assign bus.alucontrol = alucontrol;
  assign bus.illegal_op = illegal_q;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: directed and random instructions against a per-instruction behavioural model.
module tb_multicycle_controller;

  localparam logic [4:0] OP_RTYPE = 5'd0;
  localparam logic [4:0] OP_LW    = 5'd1;
  localparam logic [4:0] OP_SW    = 5'd2;
  localparam logic [4:0] OP_BEQ   = 5'd3;
  localparam logic [4:0] OP_ADDI  = 5'd4;
  localparam logic [4:0] OP_J     = 5'd5;
  localparam logic [4:0] OP_BNE   = 5'd6;

  localparam int unsigned ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMRD = 3,
                          ST_MEMWB = 4, ST_MEMWR = 5, ST_EXEC = 6, ST_ALUWB = 7,
                          ST_BEQ = 8, ST_ADDIEX = 9, ST_ADDIWB = 10, ST_JUMP = 11, ST_BNE = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_controller_if #(.OP_W(5), .FUNCT_W(6), .ALUCTRL_W(3)) bus ();

  multicycle_controller #(.OP_W(5), .FUNCT_W(6), .ALUCTRL_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  bit exp_illegal = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] alu_ref(input logic [5:0] fn);
    case (fn)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2A:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // Runs one instruction: fw fetch wait cycles, mw memory wait cycles (LW/SW only).
  task automatic exec(input logic [4:0] op, input logic [5:0] fn, input logic z,
                      input int unsigned fw, input int unsigned mw);
    int unsigned sq[$];
    logic        mq[$];
    int unsigned n_pcen = 0, n_irw = 0, n_rw = 0, n_mw = 0, n_iord = 0;
    int unsigned n_m2r = 0, n_rdst = 0, n_mrd = 0;
    bit is_lw, is_sw, is_r, is_addi, is_br, taken, legal;
    is_lw   = (op == OP_LW);
    is_sw   = (op == OP_SW);
    is_r    = (op == OP_RTYPE);
    is_addi = (op == OP_ADDI);
    is_br   = (op == OP_BEQ) || (op == OP_BNE);
    taken   = (op == OP_J) || (op == OP_BEQ && z) || (op == OP_BNE && !z);
    legal   = (op <= OP_BNE);

    for (int unsigned i = 0; i < fw; i++) begin sq.push_back(ST_FETCH); mq.push_back(1'b0); end
    sq.push_back(ST_FETCH);  mq.push_back(1'b1);
    sq.push_back(ST_DECODE); mq.push_back(1'($urandom_range(0, 1)));
    if (is_lw || is_sw) begin
      sq.push_back(ST_MEMADR); mq.push_back(1'($urandom_range(0, 1)));
      for (int unsigned i = 0; i <= mw; i++) begin
        sq.push_back(is_lw ? ST_MEMRD : ST_MEMWR);
        mq.push_back(i == mw);
      end
      if (is_lw) begin sq.push_back(ST_MEMWB); mq.push_back(1'($urandom_range(0, 1))); end
    end else if (is_r) begin
      sq.push_back(ST_EXEC);  mq.push_back(1'($urandom_range(0, 1)));
      sq.push_back(ST_ALUWB); mq.push_back(1'($urandom_range(0, 1)));
    end else if (is_addi) begin
      sq.push_back(ST_ADDIEX); mq.push_back(1'($urandom_range(0, 1)));
      sq.push_back(ST_ADDIWB); mq.push_back(1'($urandom_range(0, 1)));
    end else if (op == OP_BEQ) begin
      sq.push_back(ST_BEQ);  mq.push_back(1'($urandom_range(0, 1)));
    end else if (op == OP_BNE) begin
      sq.push_back(ST_BNE);  mq.push_back(1'($urandom_range(0, 1)));
    end else if (op == OP_J) begin
      sq.push_back(ST_JUMP); mq.push_back(1'($urandom_range(0, 1)));
    end
    if (!legal) exp_illegal = 1'b1;

    bus.op    = op;
    bus.funct = fn;
    foreach (sq[i]) begin
      bus.mem_ready = mq[i];
      bus.zero      = (sq[i] == ST_BEQ || sq[i] == ST_BNE) ? z : 1'($urandom_range(0, 1));
      @(negedge clk);
      check("state", 32'(bus.state_o), sq[i]);
      n_pcen += bus.pcen;     n_irw  += bus.irwrite;  n_rw   += bus.regwrite;
      n_mw   += bus.memwrite; n_iord += bus.iord;     n_m2r  += bus.memtoreg;
      n_rdst += bus.regdst;   n_mrd  += bus.memread;
      if (sq[i] == ST_EXEC) check("alu_exec", 32'(bus.alucontrol), 32'(alu_ref(fn)));
      if (sq[i] == ST_BEQ || sq[i] == ST_BNE) begin
        check("alu_branch", 32'(bus.alucontrol), 32'h6);
        check("pcsrc_branch", 32'(bus.pcsrc), 32'h1);
      end
      if (sq[i] == ST_JUMP) check("pcsrc_jump", 32'(bus.pcsrc), 32'h2);
      @(posedge clk); #1;
    end

    check("back_to_fetch", 32'(bus.state_o), ST_FETCH);
    check("illegal_op", 32'(bus.illegal_op), 32'(exp_illegal));
    check("pcen_cnt", n_pcen, 1 + (taken ? 1 : 0));
    check("irwrite_cnt", n_irw, 1);
    check("regwrite_cnt", n_rw, (is_lw || is_r || is_addi) ? 1 : 0);
    check("memwrite_cnt", n_mw, is_sw ? mw + 1 : 0);
    check("iord_cnt", n_iord, (is_lw || is_sw) ? mw + 1 : 0);
    check("memtoreg_cnt", n_m2r, is_lw ? 1 : 0);
    check("regdst_cnt", n_rdst, is_r ? 1 : 0);
    check("memread_cnt", n_mrd, fw + 1 + (is_lw ? mw + 1 : 0));
    if (is_br) check("branch_zero_in", 32'(bus.zero), 32'(z));
  endtask

  logic [5:0] fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] op;
    logic [5:0] fn;
    int unsigned r;

    reset = 1'b1;
    bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #2;
    check("rst_state", 32'(bus.state_o), ST_FETCH);
    check("rst_memread", 32'(bus.memread), 1);
    check("rst_irwrite", 32'(bus.irwrite), 1);
    check("rst_pcen", 32'(bus.pcen), 1);
    check("rst_regwrite", 32'(bus.regwrite), 0);
    check("rst_memwrite", 32'(bus.memwrite), 0);
    check("rst_illegal", 32'(bus.illegal_op), 0);

    exec(OP_LW,     6'h00, 1'b0, 0, 0);
    exec(OP_SW,     6'h00, 1'b0, 0, 3);
    exec(OP_BEQ,    6'h00, 1'b1, 0, 0);
    exec(OP_BNE,    6'h00, 1'b1, 0, 0);
    exec(OP_BNE,    6'h00, 1'b0, 0, 0);
    exec(OP_RTYPE,  6'h2A, 1'b0, 1, 0);
    exec(OP_RTYPE,  6'h3F, 1'b0, 0, 0);
    exec(OP_ADDI,   6'h00, 1'b0, 2, 0);
    exec(OP_J,      6'h00, 1'b0, 0, 0);
    exec(OP_LW,     6'h00, 1'b0, 0, 2);
    exec(5'h1F,     6'h00, 1'b0, 0, 0);
    exec(OP_RTYPE,  6'h22, 1'b0, 0, 0);

    // Abort an LW while it waits in MEMRD.
    bus.op = OP_LW; bus.mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("midlw_state", 32'(bus.state_o), ST_MEMRD);
    check("midlw_iord", 32'(bus.iord), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_state", 32'(bus.state_o), ST_FETCH);
    check("abort_regwrite", 32'(bus.regwrite), 0);
    check("abort_memwrite", 32'(bus.memwrite), 0);
    check("abort_illegal", 32'(bus.illegal_op), 0);
    exp_illegal = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      op = (r < 7) ? 5'(r) : 5'($urandom_range(7, 31));
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 4)];
      exec(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
